// File: rtl/clk_enable_sequencer_pkg.sv
// Shared types and widths for the PLL clock-enable sequencer.
package clkseq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int DIV_W  = 3;
    localparam int FILT_W = 4;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/clk_enable_sequencer_lock_qualifier.sv
// PLL LOCK synchronizer and consecutive-high filter; lock_ok pulses on the
// cycle the filter count reaches LOCK_FILTER.
module pll_lock_qualifier
    import clkseq_pkg::*;
#(
    parameter int LOCK_FILTER = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pll_lock,
    output logic o_lock_s,
    output logic o_lock_ok
);

    localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILTER);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [FILT_W-1:0] r_filt;

    // Count saturates so lock_ok is a single-cycle level per high streak.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= '0;
        end else begin
            r_sync1 <= i_pll_lock;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_filt <= '0;
            end else if (r_filt != FILT_MAX) begin
                r_filt <= r_filt + 1'b1;
            end
        end
    end

    assign o_lock_s  = r_sync2;
    assign o_lock_ok = r_sync2 && (r_filt == FILT_LAST);

endmodule

// File: rtl/clk_enable_sequencer.sv
// Lock-qualified reset sequencing plus /2, /4, /8 clock enables on the PLL clock.
// CLKSEQ_CONTENTION_EN enables WAIT_REQ deferral of the CPU enable.
module clk_enable_sequencer
    import clkseq_pkg::*;
#(
    parameter int LOCK_FILTER = 4,
    parameter int RESET_HOLD  = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic PLL_LOCK,
    input  logic WAIT_REQ,
    output logic CE_DIV2,
    output logic CE_DIV4,
    output logic CE_DIV8,
    output logic CPU_CE,
    output logic CPU_RST_N,
    output logic SYS_READY
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  w_hold_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIV_W-1:0]   w_div_next;
    logic               r_cpu_rst_n;
    logic               w_lock_s;
    logic               w_lock_ok;
    logic               w_run;

    pll_lock_qualifier #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_qual (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_pll_lock (PLL_LOCK),
        .o_lock_s   (w_lock_s),
        .o_lock_ok  (w_lock_ok)
    );

    // Counters default to zero so any exit from HOLD/RUN leaves them cleared.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = '0;
        w_div_next   = '0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_ok) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (!w_lock_s) begin
                    w_state_next = WAIT_LOCK;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = RUN;
                end else begin
                    w_hold_next = r_hold_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_next = WAIT_LOCK;
                end else begin
                    w_div_next = r_div_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= WAIT_LOCK;
            r_hold_cnt  <= '0;
            r_div_cnt   <= '0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_next;
            r_div_cnt   <= w_div_next;
            r_cpu_rst_n <= (r_state == RUN);
        end
    end

    assign w_run     = (r_state == RUN);
    assign SYS_READY = w_run;
    assign CPU_RST_N = r_cpu_rst_n;
    assign CE_DIV2   = w_run & r_div_cnt[0];
    assign CE_DIV4   = w_run & (r_div_cnt[1:0] == 2'b11);
    assign CE_DIV8   = w_run & (&r_div_cnt);

`ifdef CLKSEQ_CONTENTION_EN
    logic r_pending;
    logic w_pending_next;

    // One owed tick at most: repeated deferred slots collapse into one pulse.
    assign CPU_CE = w_run & ~WAIT_REQ & (CE_DIV8 | r_pending);

    always_comb begin
        w_pending_next = r_pending;
        if ((w_state_next != RUN) || CPU_CE) begin
            w_pending_next = 1'b0;
        end else if (CE_DIV8 && WAIT_REQ) begin
            w_pending_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
        end
    end
`else
    logic w_unused_wait_req;

    assign w_unused_wait_req = WAIT_REQ;
    assign CPU_CE            = CE_DIV8;
`endif

endmodule

// File: tb/tb_clk_enable_sequencer.sv
// Randomized self-checking bench for clk_enable_sequencer against a cycle-count model.
module tb_clk_enable_sequencer;

  localparam int LOCK_FILTER = 4;
  localparam int RESET_HOLD  = 16;

  logic CLK;
  logic RST_N;
  logic PLL_LOCK;
  logic WAIT_REQ;
  logic CE_DIV2;
  logic CE_DIV4;
  logic CE_DIV8;
  logic CPU_CE;
  logic CPU_RST_N;
  logic SYS_READY;

  int n_tests;
  int n_fail;

  // reference model: progress expressed as cycle counts inside each phase
  int   m_run_idx;   // 0 = not running, else 1-based RUN cycle number
  int   m_hold_idx;  // 0 = not holding, else 1-based HOLD cycle number
  int   m_streak;    // consecutive synchronized-high cycles while waiting
  logic m_sync1;
  logic m_lock_s;
  logic m_rst;
  logic m_owed;

  clk_enable_sequencer #(
    .LOCK_FILTER(LOCK_FILTER),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .PLL_LOCK (PLL_LOCK),
    .WAIT_REQ (WAIT_REQ),
    .CE_DIV2  (CE_DIV2),
    .CE_DIV4  (CE_DIV4),
    .CE_DIV8  (CE_DIV8),
    .CPU_CE   (CPU_CE),
    .CPU_RST_N(CPU_RST_N),
    .SYS_READY(SYS_READY)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_running();
    return m_run_idx != 0;
  endfunction

  function automatic logic m_ce(input int period);
    return (m_run_idx != 0) && (m_run_idx % period == 0);
  endfunction

  function automatic logic m_cpu_ce(input logic wr);
`ifdef CLKSEQ_CONTENTION_EN
    return m_running() && !wr && (m_ce(8) || m_owed);
`else
    return m_ce(8);
`endif
  endfunction

  task automatic model_reset();
    m_run_idx  = 0;
    m_hold_idx = 0;
    m_streak   = 0;
    m_sync1    = 1'b0;
    m_lock_s   = 1'b0;
    m_rst      = 1'b0;
    m_owed     = 1'b0;
  endtask

  task automatic model_update(input logic lock, input logic wr);
    logic run;
    logic cpu;
    run = m_running();
    cpu = m_cpu_ce(wr);
    if (!run || cpu) m_owed = 1'b0;
    else if (m_ce(8) && wr) m_owed = 1'b1;
    m_rst = run;
    if ((run || m_hold_idx != 0) && !m_lock_s) begin
      m_run_idx  = 0;
      m_hold_idx = 0;
      m_streak   = 0;
      m_owed     = 1'b0;
    end else if (run) begin
      m_run_idx++;
    end else if (m_hold_idx != 0) begin
      if (m_hold_idx == RESET_HOLD) begin
        m_hold_idx = 0;
        m_run_idx  = 1;
      end else begin
        m_hold_idx++;
      end
    end else begin
      m_streak = m_lock_s ? m_streak + 1 : 0;
      if (m_streak == LOCK_FILTER) begin
        m_streak   = 0;
        m_hold_idx = 1;
      end
    end
    m_lock_s = m_sync1;
    m_sync1  = lock;
  endtask

  task automatic check_outputs(input logic wr);
    check_val("sys_ready", SYS_READY, m_running());
    check_val("cpu_rst_n", CPU_RST_N, m_rst);
    check_val("ce_div2", CE_DIV2, m_ce(2));
    check_val("ce_div4", CE_DIV4, m_ce(4));
    check_val("ce_div8", CE_DIV8, m_ce(8));
    check_val("cpu_ce", CPU_CE, m_cpu_ce(wr));
  endtask

  // driver: inputs change on the falling edge, outputs checked 1 ns later
  task automatic step(input logic lock, input logic wr);
    @(negedge CLK);
    PLL_LOCK = lock;
    WAIT_REQ = wr;
    #1;
    check_outputs(wr);
    @(posedge CLK);
    model_update(lock, wr);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  function automatic logic rand_wait();
    return $urandom_range(0, 3) == 0;
  endfunction

  initial begin
    int   first_ready;
    int   first_rst;
    int   win;
    int   run_len;
    int   low_len;
    logic done;

    n_tests  = 0;
    n_fail   = 0;
    PLL_LOCK = 1'b0;
    WAIT_REQ = 1'b0;
    RST_N    = 1'b1;
    model_reset();
    #2;
    RST_N = 1'b0;
    #1;
    check_outputs(1'b0);
    do_reset();

    // lock bring-up with steady PLL_LOCK, random contention
    first_ready = -1;
    first_rst   = -1;
    for (int n = 1; n <= 100; n++) begin
      step(1'b1, rand_wait());
      #1;
      if (first_ready < 0 && SYS_READY === 1'b1) first_ready = n;
      if (first_rst < 0 && CPU_RST_N === 1'b1) first_rst = n;
    end
    check_val("ready_cycle", first_ready, 2 + LOCK_FILTER + RESET_HOLD);
    check_val("cpu_rst_cycle", first_rst, 3 + LOCK_FILTER + RESET_HOLD);

    // three-cycle contention window starting on a CE_DIV8 slot
    win  = 0;
    done = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (!done && win == 0 && m_ce(8)) begin
        win  = 3;
        done = 1'b1;
      end
      step(1'b1, win > 0);
      if (win > 0) win--;
    end

    // long contention covering several CE_DIV8 slots
    for (int n = 0; n < 20; n++) step(1'b1, 1'b1);
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0);

    // lock loss in RUN followed by relock
    for (int k = 0; k < 3; k++) begin
      run_len = $urandom_range(10, 40);
      low_len = $urandom_range(1, 4);
      for (int n = 0; n < run_len; n++) step(1'b1, rand_wait());
      for (int n = 0; n < low_len; n++) step(1'b0, rand_wait());
      for (int n = 0; n < 60; n++) step(1'b1, rand_wait());
    end

    // glitch: three highs, one low, then steady
    do_reset();
    first_ready = -1;
    for (int n = 1; n <= 60; n++) begin
      step(n != 4, rand_wait());
      #1;
      if (first_ready < 0 && SYS_READY === 1'b1) first_ready = n;
    end
    check_val("glitch_ready_cycle", first_ready, 6 + LOCK_FILTER + RESET_HOLD);

    // noisy lock then steady
    for (int n = 0; n < 40; n++) step($urandom_range(0, 1) == 1, rand_wait());
    for (int n = 0; n < 50; n++) step(1'b1, rand_wait());

    // asynchronous reset mid-cycle while running
    check_val("pre_async_run", SYS_READY, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("async_sys_ready", SYS_READY, 1'b0);
    check_val("async_cpu_rst_n", CPU_RST_N, 1'b0);
    check_val("async_ce_div2", CE_DIV2, 1'b0);
    check_val("async_ce_div4", CE_DIV4, 1'b0);
    check_val("async_ce_div8", CE_DIV8, 1'b0);
    check_val("async_cpu_ce", CPU_CE, 1'b0);
    do_reset();
    for (int n = 0; n < 50; n++) step(1'b1, rand_wait());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_enable_sequencer.md
# clk_enable_sequencer

Sequences the system clock domain that runs off the iCE40 PLL output: it qualifies the PLL lock, holds the machine in reset for a fixed period, then issues single-cycle clock enables at /2, /4 and /8 of the PLL clock. The /8 enable drives the Z80 CPU, and video RAM contention can defer it. This block replaces divided-clock fabric nets with enables, so every downstream register stays on the single PLL global clock.

## Interface
Parameters:
- LOCK_FILTER, 4: consecutive synchronized PLL_LOCK-high cycles required before leaving WAIT_LOCK (1..15).
- RESET_HOLD, 16: cycles spent in HOLD with CPU reset asserted (1..255).

Ports:
- CLK  in  1  PLL global clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- PLL_LOCK  in  1  raw PLL LOCK; asynchronous to CLK.
- WAIT_REQ  in  1  video contention request, synchronous to CLK; high = CPU must not tick.
- CE_DIV2  out  1  enable pulse, 1 cycle in 2.
- CE_DIV4  out  1  enable pulse, 1 cycle in 4.
- CE_DIV8  out  1  enable pulse, 1 cycle in 8.
- CPU_CE  out  1  CPU clock enable (CE_DIV8, possibly deferred).
- CPU_RST_N  out  1  active-low CPU/system reset, registered.
- SYS_READY  out  1  high while in RUN.

## Operation
- PLL_LOCK passes through a 2-flop synchronizer, giving lock_s.
- States:
  - WAIT_LOCK: filter counter increments while lock_s=1 and clears when lock_s=0. When it reaches LOCK_FILTER, go to HOLD.
  - HOLD: hold counter counts RESET_HOLD cycles, then go to RUN.
  - RUN: steady state.
- From HOLD or RUN, lock_s=0 forces WAIT_LOCK on the next edge. All counters and the pending flag clear.
- Divider: 3-bit cnt, cleared on entry to RUN, incremented every RUN cycle, wraps 7→0.
- Enable decode, all gated by RUN:
  - CE_DIV2 = cnt[0]
  - CE_DIV4 = (cnt[1:0]==3)
  - CE_DIV8 = (cnt==7)
- Contention logic:
  - CPU_CE = RUN & ~WAIT_REQ & (CE_DIV8 | pending).
  - pending sets when CE_DIV8=1 and WAIT_REQ=1. It clears on any cycle where CPU_CE=1.
  - If CE_DIV8 recurs while pending and WAIT_REQ=1, pending stays set. The earlier tick is dropped; pending does not count ticks.
  - If CE_DIV8 and pending coincide with WAIT_REQ=0, exactly one CPU_CE pulse is issued.
- CPU_RST_N is the registered value of (state==RUN). SYS_READY is combinational from the state register.

## Timing
- Reset values: state WAIT_LOCK, all counters 0, pending 0, every CE output 0, CPU_RST_N 0, SYS_READY 0.
- Lock-in latency: with PLL_LOCK steady high after reset, entry to HOLD occurs 2+LOCK_FILTER cycles later. RUN follows RESET_HOLD cycles after that.
- On the first RUN cycle: SYS_READY=1 and cnt=0. CPU_RST_N rises one cycle later.
- Enable positions (1-based RUN cycles):
  - First CE_DIV2 on RUN cycle 2.
  - First CE_DIV4 on RUN cycle 4.
  - First CE_DIV8 on RUN cycle 8.
  - Periods are exactly 2, 4 and 8 thereafter.
- CPU_CE depends combinationally on WAIT_REQ (zero latency). All other outputs are decodes of registers only.
- Lock loss: lock_s falls 2 cycles after PLL_LOCK. On the next edge the state becomes WAIT_LOCK, all CEs drop, and SYS_READY drops. CPU_RST_N drops one edge after that.
- Asynchronous reset mid-RUN: all outputs return to their reset values immediately, without waiting for a clock edge.

## Configuration
- CLKSEQ_CONTENTION_EN
  - Defined: WAIT_REQ deferral and the pending flag are implemented as described above.
  - Undefined: pending logic is omitted, WAIT_REQ is ignored, and CPU_CE equals CE_DIV8.

## Structure
- Package clkseq_pkg holds:
  - state enum {WAIT_LOCK, HOLD, RUN};
  - divider width constant (3);
  - counter width constants for the filter (4) and hold (8) counters.
- One sub-module, pll_lock_qualifier, contains the 2-flop synchronizer plus the LOCK_FILTER counter. Its output is a single-cycle lock_ok level to the FSM.
- FSM, divider and contention logic live in the top module.

## Test plan
- Lock bring-up:
  - Stimulus: reset released, PLL_LOCK=1 from cycle 0, defaults.
  - Response: SYS_READY rises at cycle 22; CPU_RST_N at 23; first CE_DIV8 on RUN cycle 8; periods 2/4/8 hold over 64 cycles.
- Lock glitch filtering:
  - Stimulus: PLL_LOCK high for 3 cycles, low for 1, then high.
  - Response: no HOLD entry until 4 consecutive synchronized-high cycles.
- Contention deferral:
  - Stimulus: WAIT_REQ=1 for the 3 cycles starting at a CE_DIV8 cycle.
  - Response: CPU_CE=0 at the CE_DIV8 cycle; a single CPU_CE on the first cycle WAIT_REQ=0 (3 cycles later); next CPU_CE at the following CE_DIV8.
- Long contention:
  - Stimulus: WAIT_REQ=1 for 20 cycles covering 3 CE_DIV8 slots.
  - Response: exactly one CPU_CE when WAIT_REQ falls.
- Lock loss in RUN:
  - Stimulus: drop PLL_LOCK.
  - Response: CEs and SYS_READY low 3 cycles later; CPU_RST_N low 4 cycles later; full re-sequence on relock.
- Async reset:
  - Stimulus: assert RST_N low mid-cycle in RUN.
  - Response: all outputs 0 before the next CLK edge.
- Macro off:
  - Stimulus: build without CLKSEQ_CONTENTION_EN; toggle WAIT_REQ.
  - Response: CPU_CE is identical to CE_DIV8.
